uart_tx_ctrl: RTL and testbench
===============================

UART_TX_CTRL -- requirements
Module: uart_tx_ctrl

Interface
REQ-001 Parameters SHALL be none; all frame configuration SHALL arrive on the cfg port.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 cfg  input  11 (config_t)  fields: br_div[7:0] = bit period minus 1, in clocks; word (0 = 7 data bits, 1 = 8); stop (0 = 1 stop bit, 1 = 2); en.
REQ-005 tx_data  input  8 (byte_t)  byte to transmit.
REQ-006 tx_valid  input  1  tx_data is valid.
REQ-007 tx_ready  output  1  block accepts tx_data this cycle.
REQ-008 tx  output  1  serial line; idle level is 1.
REQ-009 busy  output  1  a frame is in progress (state != IDLE).
REQ-010 frame_done  output  1  one-cycle pulse when a frame completes.

Function
REQ-011 FSM SHALL use state_t states IDLE, START, DATA and STOP only; WAIT or ERROR, if ever reached, SHALL return to IDLE on the next clock with tx = 1.
REQ-012 tx_ready SHALL equal (state == IDLE) && cfg.en, combinationally; a transfer occurs on a clock edge with tx_valid && tx_ready.
REQ-013 On a transfer, tx_data and cfg (br_div, word, stop) SHALL be latched; later cfg changes SHALL NOT affect the frame in flight.
REQ-014 The state after a transfer SHALL be START; tx SHALL be registered, driving 0 from the edge after the transfer.
REQ-015 Each bit SHALL last exactly latched br_div + 1 clocks; br_div = 0 gives 1 clock per bit, and br_div = 255 gives 256.
REQ-016 DATA SHALL send bits LSB first; in 7-bit mode it SHALL send bits [6:0] and ignore bit 7.
REQ-017 STOP SHALL drive 1 for 1 bit period, or 2 bit periods when stop = 1.
REQ-018 Total frame time SHALL be (1 + W + S) * (br_div + 1) clocks, where W is 7 or 8 and S is 1 or 2.
REQ-019 After the last stop bit, state SHALL return to IDLE and frame_done SHALL be 1 for exactly that first IDLE cycle.
REQ-020 A transfer SHALL be allowed in the frame_done cycle; back-to-back frames SHALL have exactly 1 idle clock between them, with tx = 1.
REQ-021 If en deasserts mid-frame, the current frame SHALL complete normally and no new transfer SHALL be accepted.
REQ-022 While en = 0 in IDLE, tx SHALL be 1, tx_ready 0 and busy 0.
REQ-023 The bit-period counter SHALL count down from br_div to 0, then reload; the bit index counter SHALL be 3 bits wide and SHALL NOT wrap within a frame.

Reset
REQ-024 While rst_n = 0, and immediately on its assertion, the block SHALL force: state IDLE, tx 1, busy 0, frame_done 0, and all counters and latched data to 0.
REQ-025 Reset asserted mid-frame SHALL abort the frame and leave no pending data.
REQ-026 After rst_n deasserts, the first transfer SHALL be possible on the first rising edge.

Structure
REQ-027 The block SHALL take config_t, state_t and byte_t from data_types_pkg, and SHALL NOT declare local copies of them.
REQ-028 Bit-period timing SHALL be a sub-module uart_baud_gen with inputs clk, rst_n, load, div[7:0] and output bit_end, a one-cycle pulse at the end of each period.
REQ-029 The FSM, shift register, bit counter and stop counter SHALL reside in uart_tx_ctrl.

Verification
REQ-030 br_div = 3, word = 1, stop = 0, data 0xA5 -> tx = 0,1,0,1,0,0,1,0,1,1, each bit held 4 clocks, 40 clocks total; frame_done pulses on clock 41.
REQ-031 br_div = 0, word = 0, stop = 1, data 0xFF -> tx = 0 followed by nine 1s, 10 clocks total; bit 7 has no effect.
REQ-032 Two back-to-back bytes 0x00 then 0x81, with tx_valid held high -> second start bit begins exactly 1 idle clock after the first frame_done edge; both frames are correct.
REQ-033 cfg changed from br_div = 3 to br_div = 7 during the DATA state -> frame keeps 4-clock bits; the next frame uses 8-clock bits.
REQ-034 en deasserted during START with tx_valid high -> frame completes, then tx_ready stays 0 and tx stays 1.
REQ-035 rst_n pulsed low during DATA -> tx = 1 and busy = 0 immediately and asynchronously; frame_done is never asserted for the aborted frame.

Source files
------------

// File: rtl/data_types_pkg.sv
// Shared types for the UART transmit path: frame configuration, FSM state and data byte.
package data_types_pkg;

  localparam int unsigned DIV_W     = 8;
  localparam int unsigned BYTE_W    = 8;
  localparam int unsigned BIT_IDX_W = 3;

  typedef logic [BYTE_W-1:0] byte_t;

  typedef struct packed {
    logic             en;
    logic             stop;
    logic             word;
    logic [DIV_W-1:0] br_div;
  } config_t;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    WAIT  = 3'd4,
    ERROR = 3'd5
  } state_t;

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period timer: counts down from the latched divider and pulses bit_end on the last clock.
module uart_baud_gen
  import data_types_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [DIV_W-1:0] div,
  output logic             bit_end
);

  logic [DIV_W-1:0] r_cnt;
  logic [DIV_W-1:0] r_div;

  // Divider is captured at load so the period is fixed for the whole frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
      r_div <= '0;
    end else if (load) begin
      r_cnt <= div;
      r_div <= div;
    end else if (r_cnt == '0) begin
      r_cnt <= r_div;
    end else begin
      r_cnt <= r_cnt - DIV_W'(1);
    end
  end

  assign bit_end = (r_cnt == '0);

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART transmitter: start bit, 7/8 data bits LSB first, 1/2 stop bits, config latched per frame.
module uart_tx_ctrl
  import data_types_pkg::*;
(
  input  logic    clk,
  input  logic    rst_n,
  input  config_t cfg,
  input  byte_t   tx_data,
  input  logic    tx_valid,
  output logic    tx_ready,
  output logic    tx,
  output logic    busy,
  output logic    frame_done
);

  state_t               r_state;
  byte_t                r_shift;
  logic [BIT_IDX_W-1:0] r_bit_idx;
  logic                 r_stop_cnt;
  logic                 r_word;
  logic                 r_stop;
  logic                 r_tx;
  logic                 r_busy;
  logic                 r_frame_done;

  logic                 w_xfer;
  logic                 w_bit_end;
  logic [BIT_IDX_W-1:0] w_last_idx;

  assign tx_ready   = (r_state == IDLE) && cfg.en;
  assign w_xfer     = tx_valid && tx_ready;
  assign w_last_idx = r_word ? BIT_IDX_W'(7) : BIT_IDX_W'(6);

  uart_baud_gen u_baud (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (w_xfer),
    .div     (cfg.br_div),
    .bit_end (w_bit_end)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_shift      <= '0;
      r_bit_idx    <= '0;
      r_stop_cnt   <= 1'b0;
      r_word       <= 1'b0;
      r_stop       <= 1'b0;
      r_tx         <= 1'b1;
      r_busy       <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;
      case (r_state)
        IDLE: begin
          r_tx   <= 1'b1;
          r_busy <= 1'b0;
          if (w_xfer) begin
            r_shift    <= tx_data;
            r_word     <= cfg.word;
            r_stop     <= cfg.stop;
            r_bit_idx  <= '0;
            r_stop_cnt <= 1'b0;
            r_state    <= START;
            r_tx       <= 1'b0;
            r_busy     <= 1'b1;
          end
        end
        START: begin
          if (w_bit_end) begin
            r_state   <= DATA;
            r_tx      <= r_shift[0];
            r_shift   <= {1'b0, r_shift[BYTE_W-1:1]};
            r_bit_idx <= '0;
          end
        end
        DATA: begin
          if (w_bit_end) begin
            if (r_bit_idx == w_last_idx) begin
              r_state <= STOP;
              r_tx    <= 1'b1;
            end else begin
              r_bit_idx <= r_bit_idx + BIT_IDX_W'(1);
              r_tx      <= r_shift[0];
              r_shift   <= {1'b0, r_shift[BYTE_W-1:1]};
            end
          end
        end
        STOP: begin
          r_tx <= 1'b1;
          if (w_bit_end) begin
            // Second stop period only when two stop bits were latched.
            if (r_stop && !r_stop_cnt) begin
              r_stop_cnt <= 1'b1;
            end else begin
              r_state      <= IDLE;
              r_busy       <= 1'b0;
              r_frame_done <= 1'b1;
            end
          end
        end
        default: begin
          r_state <= IDLE;
          r_tx    <= 1'b1;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign tx         = r_tx;
  assign busy       = r_busy;
  assign frame_done = r_frame_done;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Self-checking bench for uart_tx_ctrl against a bit-list frame model.
module tb_uart_tx_ctrl;
  import data_types_pkg::*;

  logic    clk;
  logic    rst_n;
  config_t cfg;
  byte_t   tx_data;
  logic    tx_valid;
  logic    tx_ready;
  logic    tx;
  logic    busy;
  logic    frame_done;

  int n_checks = 0;
  int n_fail   = 0;

  uart_tx_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cfg        (cfg),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .tx         (tx),
    .busy       (busy),
    .frame_done (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Wait for tx_ready, present one byte, return 1 time unit after the transfer edge.
  task automatic launch(input byte_t d, input logic [7:0] div, input logic w, input logic s);
    int waited = 0;
    cfg.en = 1'b1;
    @(negedge clk);
    while (!tx_ready && waited < 5000) begin
      @(negedge clk);
      waited++;
    end
    n_checks++;
    if (!tx_ready) begin
      n_fail++;
      $display("FAIL launch_timeout: tx_ready=%b required 1 within 5000 cycles", tx_ready);
    end
    tx_data    = d;
    cfg.br_div = div;
    cfg.word   = w;
    cfg.stop   = s;
    tx_valid   = 1'b1;
    @(posedge clk);
    #1 tx_valid = 1'b0;
  endtask

  // Model: frame is a list of line levels, each held div+1 clocks, then one frame_done idle clock.
  task automatic check_frame(input byte_t d, input logic [7:0] div, input logic w, input logic s,
                             input string name);
    logic q[$];
    int   cyc = 0;
    q.push_back(1'b0);
    for (int i = 0; i < (w ? 8 : 7); i++) q.push_back(d[i]);
    for (int i = 0; i < (s ? 2 : 1); i++) q.push_back(1'b1);
    foreach (q[b]) begin
      for (int k = 0; k <= int'(div); k++) begin
        @(negedge clk);
        n_checks++;
        if (tx !== q[b]) begin
          n_fail++;
          $display("FAIL %s_tx: cycle %0d bit %0d tx=%b required %b", name, cyc, b, tx, q[b]);
        end
        n_checks++;
        if ({busy, frame_done, tx_ready} !== 3'b100) begin
          n_fail++;
          $display("FAIL %s_status: cycle %0d busy/done/ready=%b required 100", name, cyc,
                   {busy, frame_done, tx_ready});
        end
        cyc++;
      end
    end
    @(negedge clk);
    n_checks++;
    if ({frame_done, tx, busy, tx_ready} !== {3'b110, cfg.en}) begin
      n_fail++;
      $display("FAIL %s_done: cycle %0d done/tx/busy/ready=%b required %b", name, cyc,
               {frame_done, tx, busy, tx_ready}, {3'b110, cfg.en});
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    cfg = '0;
    tx_data = '0;
    tx_valid = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({tx, busy, frame_done, tx_ready} !== 4'b1000) begin
      n_fail++;
      $display("FAIL reset_outputs: tx/busy/done/ready=%b required 1000", {tx, busy, frame_done, tx_ready});
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({tx, busy, frame_done, tx_ready} !== 4'b1000) begin
      n_fail++;
      $display("FAIL idle_en0: tx/busy/done/ready=%b required 1000", {tx, busy, frame_done, tx_ready});
    end
  endtask

  task automatic test_vectors();
    launch(8'hA5, 8'd3, 1'b1, 1'b0);
    check_frame(8'hA5, 8'd3, 1'b1, 1'b0, "vec_a5");
    launch(8'hFF, 8'd0, 1'b0, 1'b1);
    check_frame(8'hFF, 8'd0, 1'b0, 1'b1, "vec_ff");
    launch(8'h80, 8'd0, 1'b0, 1'b0);
    check_frame(8'h80, 8'd0, 1'b0, 1'b0, "vec_bit7_ignored");
    launch(8'h3C, 8'd255, 1'b0, 1'b0);
    check_frame(8'h3C, 8'd255, 1'b0, 1'b0, "vec_div255");
  endtask

  task automatic test_random();
    for (int n = 0; n < 16; n++) begin
      byte_t      d   = byte_t'($urandom);
      logic [7:0] div = 8'($urandom_range(0, 5));
      logic       w   = 1'($urandom);
      logic       s   = 1'($urandom);
      launch(d, div, w, s);
      check_frame(d, div, w, s, "random");
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
  endtask

  task automatic test_back_to_back();
    launch(8'h00, 8'd2, 1'b1, 1'b0);
    tx_data  = 8'h81;
    tx_valid = 1'b1;
    check_frame(8'h00, 8'd2, 1'b1, 1'b0, "b2b_first");
    @(posedge clk);
    #1 tx_valid = 1'b0;
    check_frame(8'h81, 8'd2, 1'b1, 1'b0, "b2b_second");
  endtask

  task automatic test_cfg_change();
    byte_t d = byte_t'($urandom);
    launch(d, 8'd3, 1'b1, 1'b0);
    fork
      check_frame(d, 8'd3, 1'b1, 1'b0, "cfg_hold");
      begin
        repeat (6) @(posedge clk);
        #1;
        cfg.br_div = 8'd7;
        cfg.word   = 1'b0;
        cfg.stop   = 1'b1;
      end
    join
    launch(~d, 8'd7, 1'b1, 1'b0);
    check_frame(~d, 8'd7, 1'b1, 1'b0, "cfg_next");
  endtask

  task automatic test_en_drop();
    launch(8'h5A, 8'd1, 1'b1, 1'b1);
    tx_valid = 1'b1;
    cfg.en   = 1'b0;
    check_frame(8'h5A, 8'd1, 1'b1, 1'b1, "en_drop");
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      n_checks++;
      if ({tx_ready, tx, busy} !== 3'b010) begin
        n_fail++;
        $display("FAIL en_drop_idle: cycle %0d ready/tx/busy=%b required 010", i, {tx_ready, tx, busy});
      end
    end
    tx_valid = 1'b0;
    cfg.en   = 1'b1;
  endtask

  task automatic test_reset_mid();
    launch(8'hC3, 8'd3, 1'b1, 1'b0);
    repeat (9) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({tx, busy, frame_done} !== 3'b100) begin
      n_fail++;
      $display("FAIL reset_async: tx/busy/done=%b required 100", {tx, busy, frame_done});
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++;
      if ({tx, busy, frame_done} !== 3'b100) begin
        n_fail++;
        $display("FAIL reset_hold: cycle %0d tx/busy/done=%b required 100", i, {tx, busy, frame_done});
      end
    end
    @(posedge clk);
    #1;
    tx_data    = 8'h96;
    cfg.br_div = 8'd1;
    cfg.word   = 1'b1;
    cfg.stop   = 1'b0;
    tx_valid   = 1'b1;
    rst_n      = 1'b1;
    @(posedge clk);
    #1 tx_valid = 1'b0;
    check_frame(8'h96, 8'd1, 1'b1, 1'b0, "after_reset");
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_random();
    test_back_to_back();
    test_cfg_change();
    test_en_drop();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
